// File: rtl/memory_controller_if.sv
// rtl/memory_controller_if.sv - core-side request/response bus of the memory controller
interface memory_controller_if;
  logic        memory_enable;
  logic        memory_command;
  logic [31:0] read_memory_address;
  logic [31:0] write_memory_address;
  logic [31:0] write_memory_data;
  logic [31:0] write_memory_mask;
  logic        memory_ready;
  logic        memory_valid;
  logic [31:0] read_memory_data;
  logic        bus_error;

  modport master (
    output memory_enable, memory_command, read_memory_address, write_memory_address,
           write_memory_data, write_memory_mask,
    input  memory_ready, memory_valid, read_memory_data, bus_error
  );

  modport slave (
    input  memory_enable, memory_command, read_memory_address, write_memory_address,
           write_memory_data, write_memory_mask,
    output memory_ready, memory_valid, read_memory_data, bus_error
  );
endinterface

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - single-outstanding core-to-SRAM controller with range checking
module memory_controller #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          MEMORY_WORDS = 4096,
  parameter int          READ_LATENCY = 2,
  localparam int         ADDR_WIDTH   = $clog2(MEMORY_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  memory_controller_if.slave    bus,
  output logic                  sram_enable,
  output logic                  sram_write,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [31:0]           sram_write_data,
  output logic [31:0]           sram_write_mask,
  input  logic [31:0]           sram_read_data,
  output logic [1:0]            debug_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // Window bounds kept at 33 bits so a window touching 2^32 never wraps.
  localparam logic [32:0] RANGE_LO = {1'b0, BASE_ADDRESS};
  localparam logic [32:0] RANGE_HI = RANGE_LO + (33'(MEMORY_WORDS) << 2);

  state_t      state;
  logic        command_q;
  logic [31:0] address_q;
  logic [31:0] data_q;
  logic [31:0] mask_q;
  logic        in_range_q;
  logic [2:0]  wait_count;
  logic        ready_q;
  logic        valid_q;
  logic        error_q;
  logic [31:0] rdata_q;

  logic [31:0] selected_address;
  logic        selected_in_range;
  logic [31:0] address_offset;

  assign selected_address  = bus.memory_command ? bus.write_memory_address
                                                : bus.read_memory_address;
  assign selected_in_range = ({1'b0, selected_address} >= RANGE_LO) &&
                             ({1'b0, selected_address} <  RANGE_HI);

  // Byte offset into the window; the two lane bits drop out in the shift.
  assign address_offset  = address_q - BASE_ADDRESS;
  assign sram_address    = ADDR_WIDTH'(address_offset >> 2);
  assign sram_write_data = data_q;
  assign sram_write_mask = mask_q;
  assign debug_state     = state;

  assign bus.memory_ready     = ready_q;
  assign bus.memory_valid     = valid_q;
  assign bus.bus_error        = error_q;
  assign bus.read_memory_data = rdata_q;

  // Request FSM: capture on accept, one SRAM strobe, latency wait, one-cycle response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      command_q   <= 1'b0;
      address_q   <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      in_range_q  <= 1'b0;
      wait_count  <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      rdata_q     <= '0;
      sram_enable <= 1'b0;
      sram_write  <= 1'b0;
    end else begin
      sram_enable <= 1'b0;
      sram_write  <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.memory_enable && ready_q) begin
            command_q   <= bus.memory_command;
            address_q   <= selected_address;
            data_q      <= bus.write_memory_data;
            mask_q      <= bus.write_memory_mask;
            in_range_q  <= selected_in_range;
            sram_enable <= selected_in_range;
            sram_write  <= selected_in_range & bus.memory_command;
            ready_q     <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (command_q) begin
            valid_q <= 1'b1;
            error_q <= ~in_range_q;
            state   <= RESPOND;
          end else begin
            wait_count <= 3'(READ_LATENCY - 1);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_count == 3'd0) begin
            rdata_q <= in_range_q ? sram_read_data : 32'h0;
            valid_q <= 1'b1;
            error_q <= ~in_range_q;
            state   <= RESPOND;
          end else begin
            wait_count <= wait_count - 3'd1;
          end
        end
        RESPOND: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h0000_0000, byte address of SRAM word 0.
REQ-002 SHALL have parameter MEMORY_WORDS, default 4096, SRAM depth in 32-bit words; ADDR_WIDTH = clog2(MEMORY_WORDS).
REQ-003 SHALL have parameter READ_LATENCY, default 2, SRAM read latency in cycles; legal values 1..7.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low (0 = in reset).
REQ-006 memory_enable  in  1  core request strobe.
REQ-007 memory_command  in  1  0 = read, 1 = write.
REQ-008 read_memory_address  in  32  byte address for reads.
REQ-009 write_memory_address  in  32  byte address for writes.
REQ-010 write_memory_data  in  32  store data, already lane-aligned.
REQ-011 write_memory_mask  in  32  per-bit write enable.
REQ-012 memory_ready  out  1  controller can accept a request.
REQ-013 memory_valid  out  1  one-cycle completion pulse, for reads and writes.
REQ-014 read_memory_data  out  32  read response data.
REQ-015 bus_error  out  1  one-cycle pulse, coincident with memory_valid, on an out-of-range access.
REQ-016 sram_enable, sram_write  out  1 each  SRAM access strobe and direction.
REQ-017 sram_address  out  ADDR_WIDTH  word address; sram_write_data out 32; sram_write_mask out 32.
REQ-018 sram_read_data  in  32  valid READ_LATENCY cycles after the sram_enable cycle of a read.
REQ-019 debug_state  out  2  current FSM state encoding.

Function
REQ-020 SHALL implement FSM IDLE(0), ISSUE(1), WAIT(2), RESPOND(3).
REQ-021 memory_ready SHALL be 1 only in IDLE; accept = memory_enable & memory_ready at a rising edge.
REQ-022 On accept, SHALL capture command, the selected address (read or write by command), data and mask, then go to ISSUE.
REQ-023 memory_enable outside IDLE SHALL be ignored; no request is queued.
REQ-024 Range check: in range iff BASE_ADDRESS <= addr < BASE_ADDRESS + 4*MEMORY_WORDS, evaluated at 33-bit width so no wrap.
REQ-025 sram_address = (addr - BASE_ADDRESS)[ADDR_WIDTH+1:2]; addr[1:0] SHALL be ignored.
REQ-026 ISSUE, in range: sram_enable=1 for exactly one cycle, sram_write = captured command, mask and data driven from the capture registers.
REQ-027 ISSUE, out of range: sram_enable SHALL stay 0; read response data forced to 0.
REQ-028 Write: ISSUE -> RESPOND; memory_valid 2 cycles after the accept edge.
REQ-029 Read: ISSUE -> WAIT for READ_LATENCY cycles, using a down-counter; sram_read_data registered at the end of the last WAIT cycle; then RESPOND; memory_valid READ_LATENCY+2 cycles after the accept edge.
REQ-030 RESPOND SHALL last exactly one cycle with memory_valid=1, then go to IDLE; back-to-back accept is possible on the following edge.
REQ-031 read_memory_data SHALL update only on read completion and hold until the next read completes.
REQ-032 sram_enable and sram_write SHALL be 0 in every state except ISSUE.
REQ-033 bus_error SHALL be 1 only in RESPOND of an out-of-range access; an out-of-range write SHALL not modify the SRAM.

Reset
REQ-034 Reset asserted SHALL immediately force: IDLE, memory_ready=1, memory_valid=0, bus_error=0, sram_enable=0, sram_write=0, read_memory_data=0, counter=0, capture registers=0.
REQ-035 Reset mid-transaction SHALL abort with no SRAM access after assertion and no completion pulse after release.
REQ-036 After reset release, the first accept SHALL be possible on the first rising edge.

Verification
REQ-037 Read, READ_LATENCY=2, addr 0x10, sram word 4 = 0xDEADBEEF -> sram_enable at cycle 1 with sram_address=4; memory_valid at cycle 4; read_memory_data=0xDEADBEEF.
REQ-038 Write 0x12345678, mask 0x0000FFFF, addr 0x20 -> single sram_enable/sram_write cycle with address 8 and that mask; memory_valid at cycle 2; a following read returns 0x....5678 in the low half.
REQ-039 Read addr 4*MEMORY_WORDS with BASE_ADDRESS=0 -> no sram_enable; memory_valid and bus_error together; read_memory_data=0.
REQ-040 BASE_ADDRESS=0xFFFF_F000, addr 0x0000_0004 -> out of range (no 32-bit wrap); bus_error=1.
REQ-041 memory_enable held high continuously -> requests accepted only from IDLE; ready low from cycle 1 until RESPOND ends; no dropped or duplicated pulses.
REQ-042 Reset asserted during WAIT -> outputs at reset values immediately; no memory_valid after release; the next read completes normally.
